// File: rtl/blind_pixel_encode.sv
// -----------------------------------------------------------------------------
// blind_pixel_encode
//
// Purpose:
//   Re-wraps a headerless pixel stream as an Avalon-ST Video stream. Each frame
//   is preceded by a control packet that carries the frame width, height and
//   interlace nibble. A video-type beat then opens the video packet, and the
//   pixels follow. This stage undoes the blind-pixel decode stage, so that
//   decode -> correct -> encode reproduces a standard video stream.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   din_data/valid/startofpacket/endofpacket, din_ready
//                       headerless pixel input; SOP marks the first pixel of a frame
//   im_width/im_height/im_interlaced
//                       frame geometry, captured when a frame's SOP is seen
//   dout_data/valid/startofpacket/endofpacket, dout_ready
//                       Avalon-ST Video output
// -----------------------------------------------------------------------------
module blind_pixel_encode #(
   parameter int DATA_WIDTH   = 24,
   parameter int COLOR_BITS   = 8,
   parameter int COLOR_PLANES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic                  din_valid,
   input  logic                  din_startofpacket,
   input  logic                  din_endofpacket,
   output logic                  din_ready,
   input  logic [15:0]           im_width,
   input  logic [15:0]           im_height,
   input  logic [3:0]            im_interlaced,
   output logic [DATA_WIDTH-1:0] dout_data,
   output logic                  dout_valid,
   output logic                  dout_startofpacket,
   output logic                  dout_endofpacket,
   input  logic                  dout_ready
);

   // Nine header nibbles packed COLOR_PLANES per beat.
   localparam int N_HEAD = (COLOR_PLANES == 1) ? 9 : (COLOR_PLANES == 2) ? 5 : 3;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_CTYPE = 5'b00010,
      ST_CHEAD = 5'b00100,
      ST_VTYPE = 5'b01000,
      ST_DATA  = 5'b10000
   } state_t;

   state_t                r_state;
   logic [3:0]            r_head_cnt;
   logic [15:0]           r_width;
   logic [15:0]           r_height;
   logic [3:0]            r_interlaced;

   logic [3:0]            w_nib [0:8];
   logic [DATA_WIDTH-1:0] w_head_data;
   logic                  w_last_head;

   // Header nibble order: width MS nibble first, then height, then interlace.
   assign w_nib[0] = r_width[15:12];
   assign w_nib[1] = r_width[11:8];
   assign w_nib[2] = r_width[7:4];
   assign w_nib[3] = r_width[3:0];
   assign w_nib[4] = r_height[15:12];
   assign w_nib[5] = r_height[11:8];
   assign w_nib[6] = r_height[7:4];
   assign w_nib[7] = r_height[3:0];
   assign w_nib[8] = r_interlaced;

   // Symbol gi of header beat r_head_cnt carries nibble r_head_cnt*PLANES+gi.
   // Indices past the ninth nibble (the 2-plane tail) are padded with zero.
   generate
      for (genvar gi = 0; gi < COLOR_PLANES; gi++) begin : g_sym
         logic [5:0] w_idx;
         assign w_idx = 6'(r_head_cnt) * 6'(COLOR_PLANES) + 6'(gi);
         assign w_head_data[gi*COLOR_BITS +: COLOR_BITS] =
            (w_idx < 6'd9) ? COLOR_BITS'(w_nib[w_idx[3:0]]) : '0;
      end
   endgenerate

   assign w_last_head = (r_head_cnt == 4'(N_HEAD - 1));

   // Output decode. Header and type beats depend only on registered state.
   // The DATA pass-through is combinational, which gives zero added latency.
   always_comb begin
      dout_data          = '0;
      dout_valid         = 1'b0;
      dout_startofpacket = 1'b0;
      dout_endofpacket   = 1'b0;
      din_ready          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Stray non-SOP beats are swallowed. The SOP pixel is held back
            // until the headers have gone out.
            din_ready = ~(din_valid & din_startofpacket);
         end
         ST_CTYPE: begin
            dout_valid         = 1'b1;
            dout_data          = DATA_WIDTH'(4'hF);
            dout_startofpacket = 1'b1;
         end
         ST_CHEAD: begin
            dout_valid       = 1'b1;
            dout_data        = w_head_data;
            dout_endofpacket = w_last_head;
         end
         ST_VTYPE: begin
            dout_valid         = 1'b1;
            dout_startofpacket = 1'b1;
         end
         ST_DATA: begin
            dout_data        = din_data;
            dout_valid       = din_valid;
            dout_endofpacket = din_endofpacket;
            din_ready        = dout_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_head_cnt   <= '0;
         r_width      <= '0;
         r_height     <= '0;
         r_interlaced <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (din_valid && din_startofpacket) begin
                  r_width      <= im_width;
                  r_height     <= im_height;
                  r_interlaced <= im_interlaced;
                  r_state      <= ST_CTYPE;
               end
            end
            ST_CTYPE: begin
               if (dout_ready) begin
                  r_head_cnt <= '0;
                  r_state    <= ST_CHEAD;
               end
            end
            ST_CHEAD: begin
               if (dout_ready) begin
                  r_head_cnt <= r_head_cnt + 4'd1;
                  if (w_last_head) begin
                     r_state <= ST_VTYPE;
                  end
               end
            end
            ST_VTYPE: begin
               if (dout_ready) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (din_valid && dout_ready && din_endofpacket) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blind_pixel_encode.sv
module tb_blind_pixel_encode;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] im_width;
   logic [15:0] im_height;
   logic [3:0]  im_interlaced;
   logic        dout_ready;

   // 3-plane DUT
   logic [23:0] din_data;
   logic        din_valid, din_sop, din_eop, din_ready;
   logic [23:0] dout_data;
   logic        dout_valid, dout_sop, dout_eop;

   // 1-plane DUT
   logic [7:0]  a_din_data;
   logic        a_valid, a_ready;
   logic [7:0]  a_dout_data;
   logic        a_dout_valid, a_dout_sop, a_dout_eop;

   // 2-plane DUT
   logic [15:0] b_din_data;
   logic        b_valid, b_ready;
   logic [15:0] b_dout_data;
   logic        b_dout_valid, b_dout_sop, b_dout_eop;

   logic        ab_sop, ab_eop;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   logic [25:0] q3[$];
   int          q3_cyc[$];
   logic [9:0]  qa[$];
   logic [17:0] qb[$];

   bit          rand_ready = 0;
   bit          stab_en    = 0;
   logic        stall_prev = 1'b0;
   logic [23:0] stall_d    = '0;

   blind_pixel_encode #(.DATA_WIDTH(24), .COLOR_BITS(8), .COLOR_PLANES(3)) u3 (
      .clk(clk), .rst(rst),
      .din_data(din_data), .din_valid(din_valid),
      .din_startofpacket(din_sop), .din_endofpacket(din_eop), .din_ready(din_ready),
      .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
      .dout_data(dout_data), .dout_valid(dout_valid),
      .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop), .dout_ready(dout_ready)
   );

   blind_pixel_encode #(.DATA_WIDTH(8), .COLOR_BITS(8), .COLOR_PLANES(1)) u1 (
      .clk(clk), .rst(rst),
      .din_data(a_din_data), .din_valid(a_valid),
      .din_startofpacket(ab_sop), .din_endofpacket(ab_eop), .din_ready(a_ready),
      .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
      .dout_data(a_dout_data), .dout_valid(a_dout_valid),
      .dout_startofpacket(a_dout_sop), .dout_endofpacket(a_dout_eop), .dout_ready(dout_ready)
   );

   blind_pixel_encode #(.DATA_WIDTH(16), .COLOR_BITS(8), .COLOR_PLANES(2)) u2 (
      .clk(clk), .rst(rst),
      .din_data(b_din_data), .din_valid(b_valid),
      .din_startofpacket(ab_sop), .din_endofpacket(ab_eop), .din_ready(b_ready),
      .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
      .dout_data(b_dout_data), .dout_valid(b_dout_valid),
      .dout_startofpacket(b_dout_sop), .dout_endofpacket(b_dout_eop), .dout_ready(dout_ready)
   );

   always @(posedge clk) cyc++;

   // Random downstream backpressure, changed just after each active edge.
   always @(posedge clk) begin
      #1;
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
   end

   // Output monitors: a beat transfers at the coming edge when valid & ready.
   always @(negedge clk) begin
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
         q3.push_back({dout_data, dout_sop, dout_eop});
         q3_cyc.push_back(cyc);
         $display("u3 beat data=%06h sop=%0b eop=%0b", dout_data, dout_sop, dout_eop);
      end
      if (a_dout_valid === 1'b1 && dout_ready === 1'b1) qa.push_back({a_dout_data, a_dout_sop, a_dout_eop});
      if (b_dout_valid === 1'b1 && dout_ready === 1'b1) qb.push_back({b_dout_data, b_dout_sop, b_dout_eop});
   end

   // A stalled beat must still be presented, unchanged, on the next cycle.
   always @(negedge clk) begin
      if (stab_en && stall_prev) begin
         n_total++;
         if (dout_valid !== 1'b1 || dout_data !== stall_d)
            $display("FAIL hold_stable: got valid=%0b data=%06h, need valid=1 data=%06h",
                     dout_valid, dout_data, stall_d);
         else
            n_pass++;
      end
      stall_prev = (dout_valid === 1'b1) && (dout_ready === 1'b0);
      stall_d    = dout_data;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents one pixel, optionally after random idle cycles, and holds it until accepted.
   task automatic send_px(input logic [23:0] d, input logic s, input logic e, input bit rnd_gap);
      logic acc;
      int   k;
      if (rnd_gap) begin
         for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
            din_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      din_valid = 1'b1; din_data = d; din_sop = s; din_eop = e;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = din_ready;
         @(posedge clk); #1;
         if (acc === 1'b1) break;
      end
      if (k == 200) begin
         n_total++;
         $display("FAIL send_timeout: pixel %06h not accepted, need accept within 200 cycles", d);
      end
   endtask

   task automatic test_reset();
      din_valid = 1'b1; din_sop = 1'b1;
      @(negedge clk);
      n_total++; if (dout_valid !== 1'b0) $display("FAIL rst_valid: got %b need 0", dout_valid); else n_pass++;
      n_total++; if (dout_sop !== 1'b0) $display("FAIL rst_sop: got %b need 0", dout_sop); else n_pass++;
      n_total++; if (dout_eop !== 1'b0) $display("FAIL rst_eop: got %b need 0", dout_eop); else n_pass++;
      n_total++; if (din_ready !== 1'b0) $display("FAIL rst_ready_sop: got %b need 0", din_ready); else n_pass++;
      din_valid = 1'b0; din_sop = 1'b0;
      #1;
      n_total++; if (din_ready !== 1'b1) $display("FAIL rst_ready_idle: got %b need 1", din_ready); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_total++; if (dout_valid !== 1'b0) $display("FAIL post_rst_valid: got %b need 0", dout_valid); else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_header_3p();
      logic [25:0] exp[$];
      logic [25:0] act;
      q3.delete(); q3_cyc.delete();
      im_width = 16'h0280; im_height = 16'h01E0; im_interlaced = 4'h0;
      fork
         begin
            repeat (3) @(posedge clk);
            #2;
            im_width = 16'hFFFF; im_height = 16'hFFFF; im_interlaced = 4'hF;
         end
      join_none
      @(posedge clk); #1;
      send_px(24'hA1A2A3, 1'b1, 1'b0, 1'b0);
      send_px(24'hB1B2B3, 1'b0, 1'b0, 1'b0);
      send_px(24'hC1C2C3, 1'b0, 1'b0, 1'b0);
      send_px(24'hD1D2D3, 1'b0, 1'b1, 1'b0);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      exp = '{{24'h00000F, 2'b10}, {24'h080200, 2'b00}, {24'h010000, 2'b00}, {24'h00000E, 2'b01},
              {24'h000000, 2'b10}, {24'hA1A2A3, 2'b00}, {24'hB1B2B3, 2'b00}, {24'hC1C2C3, 2'b00},
              {24'hD1D2D3, 2'b01}};
      n_total++; if (q3.size() != exp.size()) $display("FAIL hdr3_count: got %0d need %0d", q3.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
         act = (i < q3.size()) ? q3[i] : 'x;
         n_total++;
         if (act !== exp[i]) $display("FAIL hdr3_beat%0d: got %07h need %07h", i, act, exp[i]); else n_pass++;
      end
      n_total++;
      if (q3_cyc.size() < 6 || q3_cyc[5] - q3_cyc[0] != 5)
         $display("FAIL hdr3_gap: got %0d cycles from control beat to first pixel, need 5",
                  (q3_cyc.size() < 6) ? -1 : q3_cyc[5] - q3_cyc[0]);
      else n_pass++;
      $display("test_header_3p done");
   endtask

   task automatic test_planes();
      logic [9:0]  exp_a[$];
      logic [17:0] exp_b[$];
      logic [9:0]  act_a;
      logic [17:0] act_b;
      qa.delete(); qb.delete();
      im_width = 16'h1234; im_height = 16'h5678; im_interlaced = 4'hA;
      a_din_data = 8'h5C; b_din_data = 16'h3C5A;
      fork
         begin
            logic acc;
            a_valid = 1'b1;
            for (int k = 0; k < 100; k++) begin
               @(negedge clk); acc = a_ready;
               @(posedge clk); #1;
               if (acc === 1'b1) break;
            end
            a_valid = 1'b0;
         end
         begin
            logic acc;
            b_valid = 1'b1;
            for (int k = 0; k < 100; k++) begin
               @(negedge clk); acc = b_ready;
               @(posedge clk); #1;
               if (acc === 1'b1) break;
            end
            b_valid = 1'b0;
         end
      join
      repeat (3) @(negedge clk);
      exp_a = '{{8'h0F, 2'b10}, {8'h01, 2'b00}, {8'h02, 2'b00}, {8'h03, 2'b00}, {8'h04, 2'b00},
                {8'h05, 2'b00}, {8'h06, 2'b00}, {8'h07, 2'b00}, {8'h08, 2'b00}, {8'h0A, 2'b01},
                {8'h00, 2'b10}, {8'h5C, 2'b01}};
      exp_b = '{{16'h000F, 2'b10}, {16'h0201, 2'b00}, {16'h0403, 2'b00}, {16'h0605, 2'b00},
                {16'h0807, 2'b00}, {16'h000A, 2'b01}, {16'h0000, 2'b10}, {16'h3C5A, 2'b01}};
      n_total++; if (qa.size() != exp_a.size()) $display("FAIL p1_count: got %0d need %0d", qa.size(), exp_a.size()); else n_pass++;
      for (int i = 0; i < exp_a.size(); i++) begin
         act_a = (i < qa.size()) ? qa[i] : 'x;
         n_total++;
         if (act_a !== exp_a[i]) $display("FAIL p1_beat%0d: got %03h need %03h", i, act_a, exp_a[i]); else n_pass++;
      end
      n_total++; if (qb.size() != exp_b.size()) $display("FAIL p2_count: got %0d need %0d", qb.size(), exp_b.size()); else n_pass++;
      for (int i = 0; i < exp_b.size(); i++) begin
         act_b = (i < qb.size()) ? qb[i] : 'x;
         n_total++;
         if (act_b !== exp_b[i]) $display("FAIL p2_beat%0d: got %05h need %05h", i, act_b, exp_b[i]); else n_pass++;
      end
      $display("test_planes done");
   endtask

   task automatic test_idle_drop();
      q3.delete();
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'b0; din_data = 24'h0D0D00 + 24'(i);
         @(negedge clk);
         n_total++; if (din_ready !== 1'b1) $display("FAIL drop_ready%0d: got %b need 1", i, din_ready); else n_pass++;
         n_total++; if (dout_valid !== 1'b0) $display("FAIL drop_valid%0d: got %b need 0", i, dout_valid); else n_pass++;
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_total++; if (q3.size() != 0) $display("FAIL drop_out: got %0d beats need 0", q3.size()); else n_pass++;
      $display("test_idle_drop done");
   endtask

   task automatic test_one_pixel();
      logic [25:0] exp[$];
      logic [25:0] act;
      q3.delete();
      im_width = 16'h0001; im_height = 16'h0001; im_interlaced = 4'h0;
      send_px(24'h777777, 1'b1, 1'b1, 1'b0);
      din_valid = 1'b0;
      @(negedge clk);
      n_total++; if (dout_valid !== 1'b0) $display("FAIL one_idle_valid: got %b need 0", dout_valid); else n_pass++;
      n_total++; if (din_ready !== 1'b1) $display("FAIL one_idle_ready: got %b need 1", din_ready); else n_pass++;
      repeat (2) @(negedge clk);
      exp = '{{24'h00000F, 2'b10}, {24'h000000, 2'b00}, {24'h000001, 2'b00}, {24'h000100, 2'b01},
              {24'h000000, 2'b10}, {24'h777777, 2'b01}};
      n_total++; if (q3.size() != exp.size()) $display("FAIL one_count: got %0d need %0d", q3.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
         act = (i < q3.size()) ? q3[i] : 'x;
         n_total++;
         if (act !== exp[i]) $display("FAIL one_beat%0d: got %07h need %07h", i, act, exp[i]); else n_pass++;
      end
      $display("test_one_pixel done");
   endtask

   task automatic test_back_to_back();
      logic [25:0] exp[$];
      logic [25:0] act;
      q3.delete();
      im_width = 16'h0002; im_height = 16'h0001; im_interlaced = 4'h0;
      send_px(24'h100001, 1'b1, 1'b0, 1'b0);
      send_px(24'h100002, 1'b0, 1'b1, 1'b0);
      im_width = 16'h0003; im_height = 16'h0002; im_interlaced = 4'h1;
      send_px(24'h200001, 1'b1, 1'b0, 1'b0);
      send_px(24'h200002, 1'b0, 1'b1, 1'b0);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      exp = '{{24'h00000F, 2'b10}, {24'h000000, 2'b00}, {24'h000002, 2'b00}, {24'h000100, 2'b01},
              {24'h000000, 2'b10}, {24'h100001, 2'b00}, {24'h100002, 2'b01},
              {24'h00000F, 2'b10}, {24'h000000, 2'b00}, {24'h000003, 2'b00}, {24'h010200, 2'b01},
              {24'h000000, 2'b10}, {24'h200001, 2'b00}, {24'h200002, 2'b01}};
      n_total++; if (q3.size() != exp.size()) $display("FAIL b2b_count: got %0d need %0d", q3.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
         act = (i < q3.size()) ? q3[i] : 'x;
         n_total++;
         if (act !== exp[i]) $display("FAIL b2b_beat%0d: got %07h need %07h", i, act, exp[i]); else n_pass++;
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_backpressure();
      logic [25:0] exp[$];
      logic [25:0] act;
      int          k;
      q3.delete();
      im_width = 16'h0004; im_height = 16'h0002; im_interlaced = 4'h0;
      @(negedge clk);
      stab_en = 1; rand_ready = 1;
      for (int i = 0; i < 8; i++)
         send_px(24'h300000 + 24'(i), 1'(i == 0), 1'(i == 7), 1'b1);
      din_valid = 1'b0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (q3.size() >= 13) break;
      end
      rand_ready = 0; dout_ready = 1'b1; stab_en = 0;
      repeat (2) @(negedge clk);
      exp = '{{24'h00000F, 2'b10}, {24'h000000, 2'b00}, {24'h000004, 2'b00}, {24'h000200, 2'b01},
              {24'h000000, 2'b10}};
      for (int i = 0; i < 8; i++) exp.push_back({24'h300000 + 24'(i), 1'b0, 1'(i == 7)});
      n_total++; if (q3.size() != exp.size()) $display("FAIL bp_count: got %0d need %0d", q3.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
         act = (i < q3.size()) ? q3[i] : 'x;
         n_total++;
         if (act !== exp[i]) $display("FAIL bp_beat%0d: got %07h need %07h", i, act, exp[i]); else n_pass++;
      end
      $display("test_backpressure done");
   endtask

   task automatic test_reset_mid();
      logic [25:0] exp[$];
      logic [25:0] act;
      int          k;
      q3.delete();
      im_width = 16'h0280; im_height = 16'h01E0; im_interlaced = 4'h0;
      din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = 24'hEEEEEE;
      for (k = 0; k < 50; k++) begin
         @(negedge clk); #1;
         if (q3.size() >= 3) break;
      end
      n_total++; if (k == 50) $display("FAIL rmid_reach: got no CHEAD beat 1 need it within 50 cycles"); else n_pass++;
      rst = 1'b1; din_valid = 1'b0;
      #1;
      n_total++; if (dout_valid !== 1'b0) $display("FAIL rmid_valid: got %b need 0", dout_valid); else n_pass++;
      n_total++; if (dout_eop !== 1'b0) $display("FAIL rmid_eop: got %b need 0", dout_eop); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      q3.delete();
      im_width = 16'h0004; im_height = 16'h0002; im_interlaced = 4'h0;
      send_px(24'h5A5A5A, 1'b1, 1'b1, 1'b0);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      exp = '{{24'h00000F, 2'b10}, {24'h000000, 2'b00}, {24'h000004, 2'b00}, {24'h000200, 2'b01},
              {24'h000000, 2'b10}, {24'h5A5A5A, 2'b01}};
      n_total++; if (q3.size() != exp.size()) $display("FAIL rmid_count: got %0d need %0d", q3.size(), exp.size()); else n_pass++;
      for (int i = 0; i < exp.size(); i++) begin
         act = (i < q3.size()) ? q3[i] : 'x;
         n_total++;
         if (act !== exp[i]) $display("FAIL rmid_beat%0d: got %07h need %07h", i, act, exp[i]); else n_pass++;
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      rst = 1'b1;
      din_data = '0; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      a_din_data = '0; a_valid = 1'b0; b_din_data = '0; b_valid = 1'b0;
      ab_sop = 1'b1; ab_eop = 1'b1;
      im_width = '0; im_height = '0; im_interlaced = '0;
      dout_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_header_3p();
      test_planes();
      test_idle_drop();
      test_one_pixel();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
